// File: rtl/clk_div_pkg.sv
// Shared constants and integration helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int SEL_W               = 4;
    localparam int DEFAULT_HALF_PERIOD = 25000;

    // Half-period in input-clock cycles for a requested output frequency,
    // rounded to nearest; 0 parks the channel when the target is unreachable.
    function automatic int unsigned calc_half_period(input int unsigned fin_hz,
                                                     input int unsigned fout_hz);
        longint unsigned num;
        longint unsigned den;
        if (fout_hz == 0) begin
            return 0;
        end
        num = longint'(fin_hz) + longint'(fout_hz);
        den = 2 * longint'(fout_hz);
        return int'(num / den);
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, active/shadow divisor and registered COUT/TICK.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CW         = 16,
    parameter int DEFAULT_HP = DEFAULT_HALF_PERIOD
) (
    input  logic          CIN,
    input  logic          RST,
    input  logic          EN,
    input  logic          WE,
    input  logic [CW-1:0] DATA,
    input  logic          SYNC,
    output logic          COUT,
    output logic          TICK,
    output logic          PEND
);

    localparam logic [CW-1:0] HP_RST = CW'(DEFAULT_HP);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] hp_q, hp_d;
    logic [CW-1:0] shd_q, shd_d;
    logic          pend_q, pend_d;
    logic          cout_q, cout_d;
    logic          tick_q, tick_d;
    logic          terminal;

    assign terminal = (cnt_q == (hp_q - CW'(1)));

    always_comb begin
        cnt_d  = cnt_q;
        hp_d   = hp_q;
        shd_d  = shd_q;
        pend_d = pend_q;
        cout_d = cout_q;
        tick_d = 1'b0;

        if (SYNC) begin
            cnt_d  = '0;
            cout_d = 1'b0;
            if (pend_q) begin
                hp_d   = shd_q;
                pend_d = 1'b0;
            end
        end else if (hp_q == '0) begin
            // Parked: outputs held low, but a pending divisor revives the channel at once.
            cnt_d  = '0;
            cout_d = 1'b0;
            if (pend_q) begin
                hp_d   = shd_q;
                pend_d = 1'b0;
            end
        end else if (EN) begin
            if (terminal) begin
                cnt_d  = '0;
                cout_d = ~cout_q;
                tick_d = ~cout_q;
                if (pend_q) begin
                    hp_d   = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A write lands after any reload above, so a same-cycle terminal or SYNC
        // consumes the old shadow and the new value stays pending.
        if (WE) begin
            shd_d  = DATA;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge CIN) begin
        if (RST) begin
            cnt_q  <= '0;
            hp_q   <= HP_RST;
            shd_q  <= HP_RST;
            pend_q <= 1'b0;
            cout_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hp_q   <= hp_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            cout_q <= cout_d;
            tick_q <= tick_d;
        end
    end

    assign COUT = cout_q;
    assign TICK = tick_q;
    assign PEND = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent 50%-duty clock dividers sharing one divisor write port and a global phase sync.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CW         = 16,
    parameter int DEFAULT_HP = DEFAULT_HALF_PERIOD
) (
    input  logic             CIN,
    input  logic             RST,
    input  logic [NCH-1:0]   EN,
    input  logic             DIV_WE,
    input  logic [SEL_W-1:0] DIV_SEL,
    input  logic [CW-1:0]    DIV_DATA,
    input  logic             SYNC,
    output logic [NCH-1:0]   COUT,
    output logic [NCH-1:0]   TICK,
    output logic [NCH-1:0]   PEND
);

    logic [NCH-1:0] we_chan;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            // Selects at or above NCH match no channel and are dropped.
            assign we_chan[gi] = DIV_WE && (DIV_SEL == SEL_W'(gi));

            clk_div_chan #(
                .CW         (CW),
                .DEFAULT_HP (DEFAULT_HP)
            ) u_chan (
                .CIN  (CIN),
                .RST  (RST),
                .EN   (EN[gi]),
                .WE   (we_chan[gi]),
                .DATA (DIV_DATA),
                .SYNC (SYNC),
                .COUT (COUT[gi]),
                .TICK (TICK[gi]),
                .PEND (PEND[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus random traffic vs a level-countdown model.
module tb_clk_div_multi;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int DHP = 4;

    logic           CIN = 1'b0;
    logic           RST = 1'b1;
    logic [NCH-1:0] EN = '0;
    logic           DIV_WE = 1'b0;
    logic [3:0]     DIV_SEL = '0;
    logic [CW-1:0]  DIV_DATA = '0;
    logic           SYNC = 1'b0;
    logic [NCH-1:0] COUT;
    logic [NCH-1:0] TICK;
    logic [NCH-1:0] PEND;

    int checks = 0;
    int errors = 0;

    // Model: cycles left in the current COUT level, plus divisor bookkeeping.
    int m_left [NCH];
    int m_hp   [NCH];
    int m_shd  [NCH];
    bit m_pend [NCH];
    bit m_cout [NCH];
    bit m_tick [NCH];

    clk_div_multi #(.NCH(NCH), .CW(CW), .DEFAULT_HP(DHP)) dut (
        .CIN      (CIN),
        .RST      (RST),
        .EN       (EN),
        .DIV_WE   (DIV_WE),
        .DIV_SEL  (DIV_SEL),
        .DIV_DATA (DIV_DATA),
        .SYNC     (SYNC),
        .COUT     (COUT),
        .TICK     (TICK),
        .PEND     (PEND)
    );

    always #5 CIN = ~CIN;

    task automatic model_update();
        for (int ch = 0; ch < NCH; ch++) begin
            if (RST) begin
                m_hp[ch] = DHP; m_shd[ch] = DHP; m_left[ch] = DHP;
                m_pend[ch] = 0; m_cout[ch] = 0; m_tick[ch] = 0;
            end else begin
                m_tick[ch] = 0;
                if (SYNC || m_hp[ch] == 0) begin
                    m_cout[ch] = 0;
                    if (m_pend[ch]) begin m_hp[ch] = m_shd[ch]; m_pend[ch] = 0; end
                    m_left[ch] = m_hp[ch];
                end else if (EN[ch]) begin
                    m_left[ch]--;
                    if (m_left[ch] == 0) begin
                        m_cout[ch] = !m_cout[ch];
                        m_tick[ch] = m_cout[ch];
                        if (m_pend[ch]) begin m_hp[ch] = m_shd[ch]; m_pend[ch] = 0; end
                        m_left[ch] = m_hp[ch];
                    end
                end
                if (DIV_WE && int'(DIV_SEL) == ch) begin
                    m_shd[ch] = int'(DIV_DATA); m_pend[ch] = 1;
                end
            end
        end
    endtask

    // One CIN cycle: model advances on the edge, outputs checked 1 time unit later,
    // then the one-cycle strobes drop.
    task automatic step();
        logic [NCH-1:0] e_cout, e_tick, e_pend;
        @(posedge CIN);
        model_update();
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            e_cout[ch] = m_cout[ch]; e_tick[ch] = m_tick[ch]; e_pend[ch] = m_pend[ch];
        end
        checks++;
        if (COUT !== e_cout) begin errors++; $display("FAIL model_cout t=%0t got=%b exp=%b", $time, COUT, e_cout); end
        checks++;
        if (TICK !== e_tick) begin errors++; $display("FAIL model_tick t=%0t got=%b exp=%b", $time, TICK, e_tick); end
        checks++;
        if (PEND !== e_pend) begin errors++; $display("FAIL model_pend t=%0t got=%b exp=%b", $time, PEND, e_pend); end
        DIV_WE = 0; SYNC = 0; RST = 0;
    endtask

    task automatic write_div(input int ch, input int val);
        DIV_WE = 1; DIV_SEL = 4'(ch); DIV_DATA = CW'(val);
    endtask

    task automatic test_reset();
        RST = 1; EN = '0;
        step();
        checks++;
        if (COUT !== 4'h0 || TICK !== 4'h0 || PEND !== 4'h0) begin
            errors++; $display("FAIL reset_outputs cout=%b tick=%b pend=%b exp=0000", COUT, TICK, PEND);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int rises[$];
        int ticks;
        logic prev;
        RST = 1; EN = 4'hF;
        step();
        prev = COUT[0]; ticks = 0;
        for (int t = 1; t <= 20; t++) begin
            step();
            if (COUT[0] && !prev) rises.push_back(t);
            if (TICK[0]) ticks++;
            checks++;
            if (TICK[0] !== (COUT[0] && !prev)) begin
                errors++; $display("FAIL basic_tick_align t=%0d tick=%b rise=%b", t, TICK[0], COUT[0] && !prev);
            end
            prev = COUT[0];
        end
        checks++;
        if (rises.size() != 3 || rises[0] != 4 || rises[1] != 12 || rises[2] != 20) begin
            errors++; $display("FAIL basic_rises got=%p exp=4,12,20", rises);
        end
        checks++;
        if (ticks != 3) begin errors++; $display("FAIL basic_tick_count got=%0d exp=3", ticks); end
        $display("test_basic done: rises=%p", rises);
    endtask

    task automatic test_reload();
        int edges[$];
        logic prev;
        write_div(1, 5); step();
        SYNC = 1; step();
        prev = COUT[1];
        step(); step();
        write_div(1, 3); step();
        checks++;
        if (PEND[1] !== 1'b1) begin errors++; $display("FAIL reload_pend_set got=%b exp=1", PEND[1]); end
        for (int t = 4; t <= 14; t++) begin
            step();
            if (COUT[1] !== prev) edges.push_back(t);
            if (t == 5) begin
                checks++;
                if (PEND[1] !== 1'b0) begin errors++; $display("FAIL reload_pend_clear got=%b exp=0", PEND[1]); end
            end
            prev = COUT[1];
        end
        checks++;
        if (edges.size() != 4 || edges[0] != 5 || edges[1] != 8 || edges[2] != 11 || edges[3] != 14) begin
            errors++; $display("FAIL reload_edges got=%p exp=5,8,11,14", edges);
        end
        $display("test_reload done: edges=%p", edges);
    endtask

    task automatic test_coincide();
        write_div(2, 4); step();
        SYNC = 1; step();
        step(); step(); step();
        write_div(2, 2); step();
        checks++;
        if (COUT[2] !== 1'b1 || PEND[2] !== 1'b1) begin
            errors++; $display("FAIL coincide_t4 cout=%b pend=%b exp cout=1 pend=1", COUT[2], PEND[2]);
        end
        step(); step(); step();
        checks++;
        if (COUT[2] !== 1'b1 || PEND[2] !== 1'b1) begin
            errors++; $display("FAIL coincide_t7 cout=%b pend=%b exp cout=1 pend=1", COUT[2], PEND[2]);
        end
        step();
        checks++;
        if (COUT[2] !== 1'b0 || PEND[2] !== 1'b0) begin
            errors++; $display("FAIL coincide_t8 cout=%b pend=%b exp cout=0 pend=0", COUT[2], PEND[2]);
        end
        step(); step();
        checks++;
        if (COUT[2] !== 1'b1) begin errors++; $display("FAIL coincide_t10 cout=%b exp=1", COUT[2]); end
        $display("test_coincide done");
    endtask

    task automatic test_enable();
        write_div(0, 4); step();
        SYNC = 1; step();
        step(); step();
        EN[0] = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            checks++;
            if (COUT[0] !== 1'b0 || TICK[0] !== 1'b0) begin
                errors++; $display("FAIL enable_hold t=%0d cout=%b tick=%b exp 0/0", t, COUT[0], TICK[0]);
            end
        end
        EN[0] = 1;
        step();
        checks++;
        if (COUT[0] !== 1'b0) begin errors++; $display("FAIL enable_resume1 cout=%b exp=0", COUT[0]); end
        step();
        checks++;
        if (COUT[0] !== 1'b1 || TICK[0] !== 1'b1) begin
            errors++; $display("FAIL enable_resume2 cout=%b tick=%b exp 1/1", COUT[0], TICK[0]);
        end
        $display("test_enable done");
    endtask

    task automatic test_park();
        write_div(3, 0); step();
        SYNC = 1; step();
        for (int t = 0; t < 10; t++) begin
            step();
            checks++;
            if (COUT[3] !== 1'b0) begin errors++; $display("FAIL park_low t=%0d cout=%b exp=0", t, COUT[3]); end
        end
        write_div(3, 2); step();
        checks++;
        if (PEND[3] !== 1'b1) begin errors++; $display("FAIL park_pend got=%b exp=1", PEND[3]); end
        step();
        checks++;
        if (PEND[3] !== 1'b0 || COUT[3] !== 1'b0) begin
            errors++; $display("FAIL park_revive pend=%b cout=%b exp 0/0", PEND[3], COUT[3]);
        end
        step(); step();
        checks++;
        if (COUT[3] !== 1'b1) begin errors++; $display("FAIL park_rise cout=%b exp=1", COUT[3]); end
        step(); step();
        checks++;
        if (COUT[3] !== 1'b0) begin errors++; $display("FAIL park_fall cout=%b exp=0", COUT[3]); end
        $display("test_park done");
    endtask

    task automatic test_sync();
        int rise;
        logic prev;
        write_div(0, 3); step();
        for (int t = 0; t < 5; t++) step();
        write_div(1, 3); step();
        for (int t = 0; t < 20; t++) step();
        SYNC = 1; step();
        checks++;
        if (COUT[1:0] !== 2'b00) begin errors++; $display("FAIL sync_clear got=%b exp=00", COUT[1:0]); end
        for (int t = 0; t < 12; t++) begin
            step();
            checks++;
            if (COUT[0] !== COUT[1]) begin errors++; $display("FAIL sync_align t=%0d c0=%b c1=%b", t, COUT[0], COUT[1]); end
        end
        write_div(0, 7); step();
        RST = 1; SYNC = 1; step();
        checks++;
        if (COUT !== 4'h0 || PEND !== 4'h0) begin
            errors++; $display("FAIL rst_sync cout=%b pend=%b exp 0000/0000", COUT, PEND);
        end
        rise = -1; prev = COUT[0];
        for (int t = 1; t <= 6; t++) begin
            step();
            if (COUT[0] && !prev && rise < 0) rise = t;
            prev = COUT[0];
        end
        checks++;
        if (rise != DHP) begin errors++; $display("FAIL rst_sync_rise got=%0d exp=%0d", rise, DHP); end
        $display("test_sync done");
    endtask

    task automatic test_random();
        for (int t = 0; t < 600; t++) begin
            EN = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) write_div($urandom_range(0, 15), $urandom_range(0, 6));
            SYNC = ($urandom_range(0, 40) == 0);
            RST  = ($urandom_range(0, 150) == 0);
            step();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_coincide();
        test_enable();
        test_park();
        test_sync();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
